// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory responder: funct3 encodings, FSM states
// and address-width helpers.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int DefaultAddressWidth = 10;
    localparam int WordAddrWidth       = DefaultAddressWidth - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Word index width for a given byte-address width (RAM is 32 bits wide).
    function automatic int word_addr_width(input int addr_width);
        return addr_width - 2;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension, and legality checking
// of a load/store access given funct3 and the low address bits.
module lsu_align
    import mem_pkg::*;
(
    input  logic        wr,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel   = 8'(rword >> {addr_lo, 3'b000});
        half_sel   = 16'(rword >> {addr_lo[1], 4'b0000});
        byte_en    = 4'b0000;
        store_word = 32'h0;
        load_data  = 32'h0;
        err        = 1'b0;

        unique case (funct3)
            F3_B: begin
                byte_en    = 4'b0001 << addr_lo;
                store_word = {4{wdata[7:0]}};
                load_data  = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_H: begin
                err        = addr_lo[0];
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_word = {2{wdata[15:0]}};
                load_data  = {{16{half_sel[15]}}, half_sel};
            end
            F3_W: begin
                err        = |addr_lo;
                byte_en    = 4'b1111;
                store_word = wdata;
                load_data  = rword;
            end
            F3_BU: begin
                err       = wr;
                load_data = {24'h0, byte_sel};
            end
            F3_HU: begin
                err       = wr | addr_lo[0];
                load_data = {16'h0, half_sel};
            end
            default: err = 1'b1;
        endcase

        // A rejected access must never touch the RAM.
        if (err) begin
            byte_en = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: valid/ready request and response channels,
// configurable wait states, and a word-organised RAM with byte-lane writes.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int AddressWidth = 10,
    parameter int WaitStates   = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic                    req_wr_i,
    input  logic [AddressWidth-1:0] req_addr_i,
    input  logic [2:0]              req_funct3_i,
    input  logic [31:0]             req_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [31:0]             rsp_rdata_o,
    output logic                    rsp_err_o
);

    localparam int         WordBits = word_addr_width(AddressWidth);
    localparam logic [3:0] CntLoad  = 4'((WaitStates > 0) ? (WaitStates - 1) : 0);

    state_e state, state_next;
    logic [3:0] wait_cnt;

    logic                    lat_wr;
    logic [AddressWidth-1:0] lat_addr;
    logic [2:0]              lat_funct3;
    logic [31:0]             lat_wdata;

    logic                    cur_wr;
    logic [AddressWidth-1:0] cur_addr;
    logic [2:0]              cur_funct3;
    logic [31:0]             cur_wdata;

    logic        accept, access, align_err;
    logic [3:0]  byte_en;
    logic [31:0] store_word, load_data, ram_word;

    logic [31:0] mem [2**WordBits];

    assign req_ready_o = (state == IDLE) && !rst_i;
    assign rsp_valid_o = (state == RESP);
    assign accept      = req_valid_i && req_ready_o;

    // In IDLE the live request is checked/accessed; afterwards the captured copy is.
    assign cur_wr     = (state == IDLE) ? req_wr_i     : lat_wr;
    assign cur_addr   = (state == IDLE) ? req_addr_i   : lat_addr;
    assign cur_funct3 = (state == IDLE) ? req_funct3_i : lat_funct3;
    assign cur_wdata  = (state == IDLE) ? req_wdata_i  : lat_wdata;
    assign ram_word   = mem[cur_addr[AddressWidth-1:2]];

    lsu_align u_align (
        .wr         (cur_wr),
        .funct3     (cur_funct3),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .rword      (ram_word),
        .byte_en    (byte_en),
        .store_word (store_word),
        .load_data  (load_data),
        .err        (align_err)
    );

    always_comb begin
        state_next = state;
        access     = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (align_err) begin
                        state_next = RESP;
                    end else if (WaitStates == 0) begin
                        state_next = RESP;
                        access     = 1'b1;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_next = RESP;
                    access     = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            wait_cnt    <= 4'd0;
            rsp_rdata_o <= 32'h0;
            rsp_err_o   <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                wait_cnt    <= CntLoad;
                rsp_err_o   <= align_err;
                rsp_rdata_o <= 32'h0;
            end else if (state == WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata_o <= cur_wr ? 32'h0 : load_data;
                rsp_err_o   <= 1'b0;
            end
            if (state == RESP && rsp_ready_i) begin
                rsp_rdata_o <= 32'h0;
                rsp_err_o   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            lat_wr     <= req_wr_i;
            lat_addr   <= req_addr_i;
            lat_funct3 <= req_funct3_i;
            lat_wdata  <= req_wdata_i;
        end
    end

    // Gated by reset so an abandoned transaction never commits its write.
    always_ff @(posedge clk_i) begin
        if (access && cur_wr && !rst_i) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) begin
                    mem[cur_addr[AddressWidth-1:2]][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

endmodule
